// File: rtl/fetch_decode_reg_pkg.sv
// Shared core definitions: instruction format classes, field positions,
// NOP encoding and the IF/ID skid-buffer state encoding.
package fetch_decode_reg_pkg;

    // Format class carried in instr[FMT_MSB:FMT_LSB]
    localparam logic [1:0] FMT_REG   = 2'b00;
    localparam logic [1:0] FMT_IMM12 = 2'b01;
    localparam logic [1:0] FMT_IMM16 = 2'b10;
    localparam logic [1:0] FMT_JMP   = 2'b11;

    localparam int FMT_MSB = 31;
    localparam int FMT_LSB = 30;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Occupancy of the two-entry buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_e;

endpackage

// File: rtl/fetch_decode_reg_fmt_decode.sv
// Format-class decoder: maps instr[31:30] to the extender select bit.
// 0 selects a 12-bit immediate, 1 selects a 16-bit immediate.
module fmt_decode
    import fetch_decode_reg_pkg::*;
(
    input  logic [1:0] fmt,
    output logic       op_se
);

    // Map each format class to its extension width select
    always_comb begin
        op_se = 1'b0;
        case (fmt)
            FMT_REG:   op_se = 1'b0;
            FMT_IMM12: op_se = 1'b0;
            FMT_IMM16: op_se = 1'b1;
            FMT_JMP:   op_se = 1'b1;
            default:   op_se = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register built as a 2-entry skid buffer (main + skid).
// if_ready is a flop derived from the next state, so decode back-pressure
// never reaches fetch combinationally. The extension select is decoded
// when an instruction is written and stored with the entry.
module fetch_decode_reg
    import fetch_decode_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [IMM_W-1:0] id_imm,
    output logic             id_op_se,
    input  logic             flush
);

    buf_state_e      state_q, state_d;
    logic [XLEN-1:0] main_instr_q, main_instr_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d;
    logic            main_se_q, main_se_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            skid_se_q, skid_se_d;
    logic            if_ready_q, if_ready_d;
    logic            id_valid_q, id_valid_d;

    logic            in_se_s;
    logic            accept_s;
    logic            consume_s;

    fmt_decode u_fmt_decode (
        .fmt   (if_instr[FMT_MSB:FMT_LSB]),
        .op_se (in_se_s)
    );

    assign accept_s  = if_valid & if_ready_q;
    assign consume_s = id_valid_q & id_ready;

    // Next-state and entry-write logic for the skid buffer
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        main_se_d    = main_se_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_se_d    = skid_se_q;

        if (flush) begin
            // Incoming word is dropped and entries are invalidated; data
            // registers keep their contents so outputs hold steady.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_instr_d = if_instr;
                        main_pc_d    = if_pc;
                        main_se_d    = in_se_s;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        main_instr_d = if_instr;
                        main_pc_d    = if_pc;
                        main_se_d    = in_se_s;
                        state_d      = ST_ONE;
                    end else if (accept_s) begin
                        skid_instr_d = if_instr;
                        skid_pc_d    = if_pc;
                        skid_se_d    = in_se_s;
                        state_d      = ST_TWO;
                    end else if (consume_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // if_ready is low here, so only a consume can happen
                    if (consume_s) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        main_se_d    = skid_se_q;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        if_ready_d = (state_d != ST_TWO);
        id_valid_d = (state_d != ST_EMPTY);
    end

    // State, handshake flags and entry storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= XLEN'(NOP_INSTR);
            main_pc_q    <= {XLEN{1'b0}};
            main_se_q    <= 1'b0;
            skid_instr_q <= {XLEN{1'b0}};
            skid_pc_q    <= {XLEN{1'b0}};
            skid_se_q    <= 1'b0;
            if_ready_q   <= 1'b1;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            main_se_q    <= main_se_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_se_q    <= skid_se_d;
            if_ready_q   <= if_ready_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign if_ready = if_ready_q;
    assign id_valid = id_valid_q;
    assign id_instr = main_instr_q;
    assign id_pc    = main_pc_q;
    assign id_imm   = main_instr_q[IMM_W-1:0];
    assign id_op_se = main_se_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed and randomized bench for the IF/ID skid-buffer register.
module tb_fetch_decode_reg;

    logic        clk;
    logic        reset_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [15:0] id_imm;
    logic        id_op_se;
    logic        flush;

    int checks;
    int failures;

    fetch_decode_reg #(.XLEN(32), .IMM_W(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_instr (id_instr),
        .id_pc    (id_pc),
        .id_imm   (id_imm),
        .id_op_se (id_op_se),
        .flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        id_ready = rdy;
        flush    = fl;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 32'h4000_0001, 32'h0000_0040, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++;
        if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
        checks++;
        if (id_instr !== 32'h0 || id_pc !== 32'h0 || id_imm !== 16'h0 || id_op_se !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got instr=%h pc=%h imm=%h se=%b exp all 0", id_instr, id_pc, id_imm, id_op_se);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'h4000_0001 || id_pc !== 32'h0000_0040) begin
            failures++;
            $display("FAIL reset_first_accept got v=%b instr=%h pc=%h exp v=1 instr=40000001 pc=00000040", id_valid, id_instr, id_pc);
        end
        // drain to empty
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_drain got=%b exp=0", id_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] ins [3];
        logic [15:0] imm [3];
        logic        se  [3];
        ins[0] = 32'h4000_0ABC; imm[0] = 16'h0ABC; se[0] = 1'b0;
        ins[1] = 32'h8000_1234; imm[1] = 16'h1234; se[1] = 1'b1;
        ins[2] = 32'h0000_0000; imm[2] = 16'h0000; se[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ins[i], 32'h0000_0100 + 32'(i * 4), 1'b1, 1'b0);
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_instr !== ins[i] || id_pc !== 32'h0000_0100 + 32'(i * 4)
                || id_imm !== imm[i] || id_op_se !== se[i] || if_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d got v=%b instr=%h pc=%h imm=%h se=%b rdy=%b exp instr=%h imm=%h se=%b",
                         i, id_valid, id_instr, id_pc, id_imm, id_op_se, if_ready, ins[i], imm[i], se[i]);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0000_0108) begin
            failures++;
            $display("FAIL stream_hold got v=%b instr=%h pc=%h exp v=0 instr=00000000 pc=00000108", id_valid, id_instr, id_pc);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h4000_0111, 32'h0000_0200, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h8000_0222, 32'h0000_0204, 1'b0, 1'b0);
        tick();
        // now TWO; fetch keeps offering D3 while decode stalls
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (id_valid !== 1'b1 || id_instr !== 32'h4000_0111 || id_pc !== 32'h0000_0200 || if_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall_%0d got v=%b instr=%h pc=%h rdy=%b exp v=1 instr=40000111 pc=00000200 rdy=0",
                         i, id_valid, id_instr, id_pc, if_ready);
            end
            drive(1'b1, 32'hC000_0333, 32'h0000_0208, 1'b0, 1'b0);
            if (i < 2) tick();
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'h8000_0222 || id_op_se !== 1'b1 || if_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release1 got v=%b instr=%h se=%b rdy=%b exp v=1 instr=80000222 se=1 rdy=1",
                     id_valid, id_instr, id_op_se, if_ready);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'hC000_0333 || id_pc !== 32'h0000_0208 || id_op_se !== 1'b1) begin
            failures++;
            $display("FAIL bp_release2 got v=%b instr=%h pc=%h se=%b exp v=1 instr=c0000333 pc=00000208 se=1",
                     id_valid, id_instr, id_pc, id_op_se);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got v=%b exp=0 (duplicate entry)", id_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h4000_0AAA, 32'h0000_0300, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4000_0BBB, 32'h0000_0304, 1'b0, 1'b0);
        tick();
        checks++;
        if (if_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_two rdy got=%b exp=0", if_ready); end
        drive(1'b1, 32'h4000_0CCC, 32'h0000_0308, 1'b0, 1'b1);
        tick();
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_two got v=%b rdy=%b exp v=0 rdy=1", id_valid, if_ready);
        end
        // ONE state, flush together with an accepted word
        drive(1'b1, 32'h4000_0DDD, 32'h0000_030C, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h8000_0EEE, 32'h0000_0310, 1'b0, 1'b1);
        tick();
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_instr !== 32'h4000_0DDD) begin
            failures++;
            $display("FAIL flush_one got v=%b rdy=%b instr=%h exp v=0 rdy=1 instr=40000ddd", id_valid, if_ready, id_instr);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_stale got v=%b exp=0", id_valid); end
        drive(1'b1, 32'h4000_0FFF, 32'h0000_0314, 1'b1, 1'b0);
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'h4000_0FFF || id_pc !== 32'h0000_0314) begin
            failures++;
            $display("FAIL flush_after got v=%b instr=%h pc=%h exp v=1 instr=40000fff pc=00000314", id_valid, id_instr, id_pc);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h8000_5555, 32'h0000_0400, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (id_valid !== 1'b1) begin failures++; $display("FAIL async_pre got v=%b exp=1", id_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_instr !== 32'h0 || id_op_se !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got v=%b rdy=%b instr=%h se=%b exp v=0 rdy=1 instr=0 se=0",
                     id_valid, if_ready, id_instr, id_op_se);
        end
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] q_ins [$];
        logic [31:0] q_pc  [$];
        logic        rdy_exp;
        logic        v, r, fl, acc, con;
        logic [31:0] ins, pc;
        int          rnd_fail;
        rnd_fail = 0;
        rdy_exp  = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            v   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 3) != 0);
            fl  = 1'($urandom_range(0, 15) == 0);
            ins = $urandom;
            pc  = $urandom;
            drive(v, ins, pc, r, fl);
            acc = v & rdy_exp;
            con = (q_ins.size() > 0) & r;
            tick();
            if (con) begin
                void'(q_ins.pop_front());
                void'(q_pc.pop_front());
            end
            if (acc && !fl) begin
                q_ins.push_back(ins);
                q_pc.push_back(pc);
            end
            if (fl) begin
                q_ins.delete();
                q_pc.delete();
            end
            rdy_exp = (q_ins.size() < 2);
            checks++;
            if (if_ready !== rdy_exp || id_valid !== (q_ins.size() > 0)) begin
                failures++;
                $display("FAIL rand_flags cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b",
                         c, id_valid, if_ready, (q_ins.size() > 0), rdy_exp);
            end
            if (q_ins.size() > 0) begin
                checks++;
                if (id_instr !== q_ins[0] || id_pc !== q_pc[0] || id_imm !== q_ins[0][15:0]) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d got instr=%h pc=%h imm=%h exp instr=%h pc=%h",
                             c, id_instr, id_pc, id_imm, q_ins[0], q_pc[0]);
                end
            end
            checks++;
            if (id_op_se !== id_instr[31]) begin
                failures++;
                $display("FAIL rand_op_se cyc=%0d got=%b exp=%b", c, id_op_se, id_instr[31]);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
